uart_prog_loader: RTL and testbench

//  Boot loader between the UART RX/TX buffers, the program RAM write port and the core.
//  Out of reset it holds the core in reset and receives a length-prefixed program image over UART.
//  It writes the image into program RAM, optionally verifies an XOR checksum and sends an ack byte.
//  It then releases the core. The processor top gains run-time program loading without a resynthesis.

---
 rtl/uart_prog_loader_pkg.sv | 31 +++
 rtl/uart_prog_loader_if.sv | 25 ++
 rtl/uart_prog_loader_byte_assembler.sv | 42 ++++
 rtl/uart_prog_loader.sv | 187 ++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared constants and helpers for the UART program loader: FSM state codes,
// default acknowledge bytes and width helpers.
package uart_prog_loader_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_LEN  = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_CSUM = 3'd2;
  localparam logic [2:0] ST_ACK  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;
  localparam logic [2:0] ST_RUN  = 3'd5;
  localparam logic [2:0] ST_HALT = 3'd6;

  localparam logic [7:0] ACK_OK_DEF  = 8'hAA;
  localparam logic [7:0] ACK_ERR_DEF = 8'h55;

  function automatic int unsigned bytes_per_word(input int unsigned word_w);
    return word_w / 32'd8;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for a byte index; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Bus bundle between the loader and its RX/TX byte buffers and the program RAM
// write port. master = loader side, slave = buffers/RAM side.
interface uart_prog_loader_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 17
);
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              rx_next;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              pw_en;
  logic [ADDR_W-1:0] pw_addr;
  logic [WORD_W-1:0] pw_data;

  modport master (
    input  rx_data, rx_ready,
    output rx_next, tx_data, tx_valid, pw_en, pw_addr, pw_data
  );

  modport slave (
    output rx_data, rx_ready,
    input  rx_next, tx_data, tx_valid, pw_en, pw_addr, pw_data
  );
endinterface

// File: rtl/uart_prog_loader_byte_assembler.sv
// Little-endian byte collector: each push stores din at the current byte slot;
// `last` flags the push that fills slot last_idx, after which the count restarts.
module uart_prog_loader_byte_assembler
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [7:0]                      din,
  input  logic [cnt_width(NBYTES)-1:0]    last_idx,
  output logic [NBYTES*8-1:0]             value,
  output logic                            last
);
  localparam int unsigned CW = cnt_width(NBYTES);
  localparam int unsigned VW = NBYTES * 8;

  logic [CW-1:0] cnt_r;
  logic [VW-1:0] value_r;

  assign value = value_r;
  assign last  = push && (cnt_r == last_idx);

  // Byte slot store; slot 0 of a new group clears the stale upper bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CW{1'b0}};
      value_r <= {VW{1'b0}};
    end else if (push) begin
      cnt_r <= last ? {CW{1'b0}} : cnt_r + {{(CW-1){1'b0}}, 1'b1};
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (cnt_r == CW'(i)) begin
          value_r[i*8 +: 8] <= din;
        end else if (cnt_r == {CW{1'b0}}) begin
          value_r[i*8 +: 8] <= 8'h00;
        end
      end
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: holds the core in reset, receives a length-prefixed image over
// the UART RX buffer, writes it to program RAM, acks over TX, then releases the core.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned LEN_BYTES = 4,
  parameter bit          CHECKSUM  = 1'b1,
  parameter logic [7:0]  ACK_OK    = ACK_OK_DEF,
  parameter logic [7:0]  ACK_ERR   = ACK_ERR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  uart_prog_loader_if.master bus,
  output logic               core_rstn,
  output logic               done,
  output logic               error
);
  localparam int unsigned BPW       = bytes_per_word(WORD_W);
  localparam int unsigned ASM_BYTES = max_u(LEN_BYTES, BPW);
  localparam int unsigned ASM_W     = ASM_BYTES * 8;
  localparam int unsigned CW        = cnt_width(ASM_BYTES);
  localparam int unsigned LEN_W     = LEN_BYTES * 8;
  // Depth held one bit wider than N so the oversize test never truncates.
  localparam logic [LEN_W:0] DEPTH_X = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  state_t            state_r;
  logic              rx_next_r;
  logic              pend_r;
  logic [LEN_W-1:0]  n_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        csum_r;
  logic              tx_valid_r;
  logic [7:0]        tx_data_r;
  logic              pw_en_r;
  logic [ADDR_W-1:0] pw_addr_r;
  logic [WORD_W-1:0] pw_data_r;
  logic              core_rstn_r;
  logic              done_r;
  logic              error_r;

  logic              consume_s;
  logic              sample_s;
  logic              push_s;
  logic [CW-1:0]     last_idx_s;
  logic [ASM_W-1:0]  asm_value_s;
  logic              asm_last_s;
  logic [LEN_W-1:0]  len_val_s;
  logic [WORD_W-1:0] word_s;
  logic              last_word_s;
  logic              oversize_s;

  assign bus.rx_next  = rx_next_r;
  assign bus.tx_valid = tx_valid_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.pw_en    = pw_en_r;
  assign bus.pw_addr  = pw_addr_r;
  assign bus.pw_data  = pw_data_r;
  assign core_rstn    = core_rstn_r;
  assign done         = done_r;
  assign error        = error_r;

  assign len_val_s   = asm_value_s[LEN_W-1:0];
  assign word_s      = asm_value_s[WORD_W-1:0];
  assign last_word_s = (LEN_W'(addr_r) == (n_r - LEN_W'(1)));
  assign oversize_s  = ({1'b0, len_val_s} > DEPTH_X);

  // Pop decision: the cycle after a pop (and its group-end cycle) never samples rx_ready.
  always_comb begin
    consume_s = 1'b0;
    sample_s  = 1'b0;
    push_s    = 1'b0;
    case (state_r)
      ST_LEN, ST_DATA, ST_CSUM, ST_HALT: consume_s = 1'b1;
      default:                           consume_s = 1'b0;
    endcase
    if (consume_s && bus.rx_ready && !rx_next_r && !pend_r) begin
      sample_s = 1'b1;
    end else begin
      sample_s = 1'b0;
    end
    if (sample_s && ((state_r == ST_LEN) || (state_r == ST_DATA))) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Group length selects between the header and a data word.
  always_comb begin
    last_idx_s = CW'(BPW - 1);
    if (state_r == ST_LEN) begin
      last_idx_s = CW'(LEN_BYTES - 1);
    end else begin
      last_idx_s = CW'(BPW - 1);
    end
  end

  uart_prog_loader_byte_assembler #(
    .NBYTES (ASM_BYTES)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .din      (bus.rx_data),
    .last_idx (last_idx_s),
    .value    (asm_value_s),
    .last     (asm_last_s)
  );

  // Load sequencer, checksum, word address and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_LEN;
      rx_next_r   <= 1'b0;
      pend_r      <= 1'b0;
      n_r         <= {LEN_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      csum_r      <= 8'h00;
      tx_valid_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      pw_en_r     <= 1'b0;
      pw_addr_r   <= {ADDR_W{1'b0}};
      pw_data_r   <= {WORD_W{1'b0}};
      core_rstn_r <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      rx_next_r  <= sample_s;
      pend_r     <= asm_last_s;
      tx_valid_r <= 1'b0;
      pw_en_r    <= 1'b0;
      if (sample_s && (state_r == ST_DATA)) begin
        csum_r <= csum_r ^ bus.rx_data;
      end
      case (state_r)
        ST_LEN: begin
          if (pend_r) begin
            n_r <= len_val_s;
            if (len_val_s == {LEN_W{1'b0}}) begin
              state_r <= ST_ACK;
            end else if (oversize_s) begin
              state_r <= ST_ERR;
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (pend_r) begin
            pw_en_r   <= 1'b1;
            pw_addr_r <= addr_r;
            pw_data_r <= word_s;
            if (last_word_s) begin
              state_r <= CHECKSUM ? ST_CSUM : ST_ACK;
            end else begin
              addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_CSUM: begin
          if (sample_s) begin
            state_r <= (bus.rx_data == csum_r) ? ST_ACK : ST_ERR;
          end
        end
        ST_ACK: begin
          tx_valid_r  <= 1'b1;
          tx_data_r   <= ACK_OK;
          core_rstn_r <= 1'b1;
          done_r      <= 1'b1;
          state_r     <= ST_RUN;
        end
        ST_ERR: begin
          tx_valid_r <= 1'b1;
          tx_data_r  <= ACK_ERR;
          error_r    <= 1'b1;
          state_r    <= ST_HALT;
        end
        ST_RUN:  state_r <= ST_RUN;
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench: random and directed program images through an RX-buffer
// model, checked against an image-level reference of the load protocol.
module tb_uart_prog_loader;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rstn, done, error;

  always #5 clk = ~clk;

  uart_prog_loader_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  uart_prog_loader #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LEN_BYTES(4), .CHECKSUM(1'b1),
    .ACK_OK(8'hAA), .ACK_ERR(8'h55)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_rstn(core_rstn), .done(done), .error(error)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  img[$];
  bit          gaps_en = 1'b0;
  int          gap_cnt = 0;

  int          pops, consec, timing_bad;
  bit          prev_rx_next;
  logic [3:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tx_q[$];

  logic [31:0] exp_data[$];
  logic [7:0]  exp_tx;
  bit          exp_done, exp_err;
  int          exp_pops;
  logic [7:0]  build_x;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RX buffer: the head leaves at the end of a cycle in which rx_next was high.
  always @(posedge clk) begin
    if (bus.rx_next && rx_q.size() > 0) void'(rx_q.pop_front());
  end

  always @(negedge clk) begin
    if (gaps_en && gap_cnt == 0 && $urandom_range(0, 3) == 0) gap_cnt = $urandom_range(1, 20);
    if (gap_cnt > 0) begin
      gap_cnt--;
      bus.rx_ready = 1'b0;
    end else begin
      bus.rx_ready = (rx_q.size() > 0);
    end
    bus.rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_rx_next = 1'b0;
    end else begin
      if (bus.rx_next) begin
        pops++;
        if (prev_rx_next) consec++;
      end
      if (bus.pw_en) begin
        if (!(prev_rx_next && pops == 4 + 4 * (wr_data_q.size() + 1))) timing_bad++;
        wr_addr_q.push_back(bus.pw_addr);
        wr_data_q.push_back(bus.pw_data);
      end
      if (bus.tx_valid) tx_q.push_back(bus.tx_data);
      prev_rx_next = bus.rx_next;
    end
  end

  task automatic clear_mon();
    pops = 0; consec = 0; timing_bad = 0;
    wr_addr_q.delete(); wr_data_q.delete(); tx_q.delete();
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val({name, ":rst_outs"},
              {14'd0, bus.rx_next, bus.tx_valid, bus.tx_data, bus.pw_en, bus.pw_addr,
               bus.pw_data, core_rstn, done, error}, 64'd0);
    rx_q.delete();
    clear_mon();
    rst = 1'b0;
  endtask

  // Image builders
  task automatic img_start(input logic [31:0] n);
    img.delete();
    build_x = 8'h00;
    for (int i = 0; i < 4; i++) img.push_back(8'((n >> (8 * i)) & 32'hFF));
  endtask

  task automatic img_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      img.push_back(8'((w >> (8 * i)) & 32'hFF));
      build_x = build_x ^ 8'((w >> (8 * i)) & 32'hFF);
    end
  endtask

  task automatic img_tail(input bit with_csum, input logic [7:0] flip, input int trailing);
    if (with_csum) img.push_back(build_x ^ flip);
    for (int i = 0; i < trailing; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: interpret the byte stream by the protocol rules.
  task automatic model();
    int unsigned n;
    logic [7:0] x;
    exp_data.delete();
    n = 32'(img[0]) + (32'(img[1]) << 8) + (32'(img[2]) << 16) + (32'(img[3]) << 24);
    x = 8'h00;
    if (n == 0) begin
      exp_tx = 8'hAA; exp_done = 1'b1; exp_err = 1'b0; exp_pops = 4;
    end else if (n > DEPTH) begin
      exp_tx = 8'h55; exp_done = 1'b0; exp_err = 1'b1; exp_pops = img.size();
    end else begin
      for (int k = 0; k < int'(n); k++) begin
        logic [31:0] w;
        w = 32'd0;
        for (int b = 0; b < 4; b++) begin
          w = w + (32'(img[4 + 4 * k + b]) << (8 * b));
          x = x ^ img[4 + 4 * k + b];
        end
        exp_data.push_back(w);
      end
      if (img[4 + 4 * n] == x) begin
        exp_tx = 8'hAA; exp_done = 1'b1; exp_err = 1'b0; exp_pops = 4 + 4 * int'(n) + 1;
      end else begin
        exp_tx = 8'h55; exp_done = 1'b0; exp_err = 1'b1; exp_pops = img.size();
      end
    end
  endtask

  task automatic run_image(input string name, input bit gaps, input bit do_rst);
    int cyc;
    if (do_rst) pulse_reset(name);
    model();
    gaps_en = gaps;
    foreach (img[i]) rx_q.push_back(img[i]);
    cyc = 0;
    while (!(done || error) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check_val({name, ":finished"}, {63'd0, done | error}, 64'd1);
    repeat (40) @(negedge clk);
    cyc = 0;
    while (exp_err && rx_q.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    check_val({name, ":nwr"}, 64'(wr_data_q.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < wr_data_q.size(); i++) begin
      check_val({name, ":wr_addr"}, 64'(wr_addr_q[i]), 64'(i));
      check_val({name, ":wr_data"}, 64'(wr_data_q[i]), 64'(exp_data[i]));
    end
    check_val({name, ":ntx"}, 64'(tx_q.size()), 64'd1);
    if (tx_q.size() > 0) check_val({name, ":tx_byte"}, 64'(tx_q[0]), 64'(exp_tx));
    check_val({name, ":done"}, {63'd0, done}, {63'd0, exp_done});
    check_val({name, ":error"}, {63'd0, error}, {63'd0, exp_err});
    check_val({name, ":core_rstn"}, {63'd0, core_rstn}, {63'd0, exp_done});
    check_val({name, ":pops"}, 64'(pops), 64'(exp_pops));
    check_val({name, ":rx_left"}, 64'(rx_q.size()), 64'(img.size() - exp_pops));
    check_val({name, ":rx_next_b2b"}, 64'(consec), 64'd0);
    check_val({name, ":wr_timing"}, 64'(timing_bad), 64'd0);
    gaps_en = 1'b0;
  endtask

  task automatic build_t1(input logic [7:0] flip, input int trailing);
    img_start(32'd3);
    img_word(32'h11223344);
    img_word(32'h55667788);
    img_word(32'h99AABBCC);
    img_tail(1'b1, flip, trailing);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    build_t1(8'h00, 2);
    run_image("t1_ok", 1'b0, 1'b1);

    img_start(32'd0);
    img_tail(1'b0, 8'h00, 2);
    run_image("t2_empty", 1'b0, 1'b1);

    img_start(32'd17);
    img_tail(1'b0, 8'h00, 5);
    run_image("t3_oversize", 1'b0, 1'b1);

    img_start(32'd16);
    for (int i = 0; i < 16; i++) img_word($urandom);
    img_tail(1'b1, 8'h00, 1);
    run_image("n_eq_depth", 1'b0, 1'b1);

    build_t1(8'h01, 0);
    run_image("t4_badsum", 1'b0, 1'b1);

    build_t1(8'h00, 1);
    run_image("t5_stalls", 1'b1, 1'b1);

    // Reset mid-load after the sixth byte has been popped.
    pulse_reset("t6_pre");
    build_t1(8'h00, 0);
    foreach (img[i]) rx_q.push_back(img[i]);
    cyc = 0;
    while (pops < 6 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_val("t6:reached_byte6", 64'(pops), 64'd6);
    pulse_reset("t6_mid");
    build_t1(8'h00, 0);
    run_image("t6_reload", 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 16);
      img_start(32'(n));
      for (int i = 0; i < n; i++) img_word($urandom);
      img_tail(1'b1, ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
               $urandom_range(0, 3));
      run_image("rand", r[0], 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
